// File: rtl/i2s_rx_pkg.sv
// Shared defaults and types for the I2S record capture path.
package i2s_rx_pkg;

  localparam int unsigned SLOT_BITS_DEF   = 32;
  localparam int unsigned SAMPLE_BITS_DEF = 24;

  typedef enum logic {IDLE, RUN} rx_state_t;
  typedef enum logic {CH_LEFT, CH_RIGHT} i2s_ch_t;

  // Sign-extend the low `bits` bits of v to a full word.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int unsigned bits);
    logic [31:0] t;
    t = v << (32 - bits);
    return $signed(t) >>> (32 - bits);
  endfunction

endpackage

// File: rtl/i2s_rx_bram_capture_clkgen.sv
// I2S master clock generator: bit clock, word select and per-bit strobes.
module i2s_clkgen #(
  parameter int unsigned BCLK_DIV  = 32,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         run_i,
  output logic                         bclk_o,
  output logic                         lrclk_o,
  output logic [$clog2(SLOT_BITS)-1:0] bit_cnt_o,
  output logic                         fall_stb_o,
  output logic                         rise_stb_o,
  output logic                         slot_end_o
);

  localparam int unsigned DivW = $clog2(BCLK_DIV);
  localparam int unsigned BitW = $clog2(SLOT_BITS);
  localparam int unsigned Half = BCLK_DIV / 2;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            lrclk_q, lrclk_d;
  logic            bclk_q, bclk_d;

  // Bit index and word select advance as div_cnt wraps to 0, i.e. together with the bclk fall.
  always_comb begin
    div_cnt_d = '0;
    bit_cnt_d = '0;
    lrclk_d   = 1'b0;
    if (run_i) begin
      div_cnt_d = div_cnt_q + DivW'(1);
      bit_cnt_d = bit_cnt_q;
      lrclk_d   = lrclk_q;
      if (div_cnt_q == DivW'(BCLK_DIV - 1)) begin
        div_cnt_d = '0;
        if (bit_cnt_q == BitW'(SLOT_BITS - 1)) begin
          bit_cnt_d = '0;
          lrclk_d   = ~lrclk_q;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
    end
    bclk_d = (div_cnt_d >= DivW'(Half));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign lrclk_o    = lrclk_q;
  assign bit_cnt_o  = bit_cnt_q;
  assign fall_stb_o = run_i && (div_cnt_q == '0);
  assign rise_stb_o = run_i && (div_cnt_q == DivW'(Half));
  assign slot_end_o = run_i && (div_cnt_q == DivW'(BCLK_DIV - 1)) &&
                      (bit_cnt_q == BitW'(SLOT_BITS - 1));

endmodule

// File: rtl/i2s_rx_bram_capture.sv
// I2S master receiver that writes each left/right sample into a BRAM ring buffer.
module i2s_rx_bram_capture
  import i2s_rx_pkg::*;
#(
  parameter int unsigned BCLK_DIV    = 32,
  parameter int unsigned SLOT_BITS   = SLOT_BITS_DEF,
  parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int unsigned BUF_WORDS   = 1024,
  parameter logic [31:0] BRAM_BASE   = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic                         rec_bclk,
  output logic                         rec_lrclk,
  input  logic                         rec_dat,
  output logic [31:0]                  BRAM_addr,
  output logic                         BRAM_clk,
  output logic [31:0]                  BRAM_din,
  input  logic [31:0]                  BRAM_dout,
  output logic                         BRAM_en,
  output logic                         BRAM_rst,
  output logic [3:0]                   BRAM_we,
  output logic [$clog2(BUF_WORDS)-1:0] wr_index,
  output logic                         irq_half,
  output logic                         irq_wrap
);

  localparam int unsigned IdxW = $clog2(BUF_WORDS);
  localparam int unsigned BitW = $clog2(SLOT_BITS);

  rx_state_t              state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic                   en_q, en_d;
  logic [31:0]            din_q, din_d;
  logic [31:0]            addr_q, addr_d;
  logic [IdxW-1:0]        wr_index_q, wr_index_d;
  logic                   irq_half_q, irq_half_d;
  logic                   irq_wrap_q, irq_wrap_d;

  logic                   run;
  logic                   start;
  logic [BitW-1:0]        bit_cnt;
  logic                   fall_stb, rise_stb, slot_end;
  logic                   wr_stb;
  logic [SAMPLE_BITS-1:0] sample_full;

  // Dropping enable stops the clocks at once, so a partial sample never completes.
  assign run   = (state_q == RUN) && enable;
  assign start = (state_q == IDLE) && enable;

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) u_clkgen (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_i     (run),
    .bclk_o    (rec_bclk),
    .lrclk_o   (rec_lrclk),
    .bit_cnt_o (bit_cnt),
    .fall_stb_o(fall_stb),
    .rise_stb_o(rise_stb),
    .slot_end_o(slot_end)
  );

  assign sample_full = {shift_q[SAMPLE_BITS-2:0], sync_q[1]};
  assign wr_stb      = rise_stb && (bit_cnt == BitW'(SAMPLE_BITS));

  always_comb begin
    state_d = enable ? RUN : IDLE;
    sync_d  = {sync_q[0], rec_dat};

    shift_d = shift_q;
    if (!run || slot_end) begin
      shift_d = '0;
    end else if (rise_stb && (bit_cnt >= BitW'(1)) && (bit_cnt <= BitW'(SAMPLE_BITS))) begin
      shift_d = sample_full;
    end

    en_d   = wr_stb;
    din_d  = wr_stb ? sext32(32'(sample_full), SAMPLE_BITS) : 32'h0;
    addr_d = wr_stb ? BRAM_BASE + (32'(wr_index_q) << 2) : BRAM_BASE;

    // Ring depth is a power of two, so the increment wraps naturally.
    wr_index_d = wr_index_q;
    if (start) begin
      wr_index_d = '0;
    end else if (en_q) begin
      wr_index_d = wr_index_q + IdxW'(1);
    end

    irq_half_d = en_q && (wr_index_q == IdxW'(BUF_WORDS / 2 - 1));
    irq_wrap_d = en_q && (wr_index_q == IdxW'(BUF_WORDS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      shift_q    <= '0;
      en_q       <= 1'b0;
      din_q      <= 32'h0;
      addr_q     <= BRAM_BASE;
      wr_index_q <= '0;
      irq_half_q <= 1'b0;
      irq_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      shift_q    <= shift_d;
      en_q       <= en_d;
      din_q      <= din_d;
      addr_q     <= addr_d;
      wr_index_q <= wr_index_d;
      irq_half_q <= irq_half_d;
      irq_wrap_q <= irq_wrap_d;
    end
  end

  assign BRAM_clk  = clk;
  assign BRAM_rst  = rst;
  assign BRAM_en   = en_q;
  assign BRAM_we   = {4{en_q}};
  assign BRAM_din  = din_q;
  assign BRAM_addr = addr_q;
  assign wr_index  = wr_index_q;
  assign irq_half  = irq_half_q;
  assign irq_wrap  = irq_wrap_q;

  // Read port and bit-start strobe are not needed on this write-only path.
  logic unused_inputs;
  assign unused_inputs = ^{BRAM_dout, fall_stb};

endmodule

// File: tb/tb_i2s_rx_bram_capture.sv
// Randomized scoreboard bench for i2s_rx_bram_capture with a behavioural codec model.
module tb_i2s_rx_bram_capture;

  localparam int unsigned Div   = 8;
  localparam int unsigned Words = 8;

  logic        clk = 1'b0;
  logic        rst, enable, rec_dat;
  logic        rec_bclk, rec_lrclk;
  logic [31:0] bram_addr, bram_din;
  logic        bram_clk, bram_en, bram_rst;
  logic [3:0]  bram_we;
  logic [2:0]  wr_index;
  logic        irq_half, irq_wrap;
  logic [31:0] bram_dout = 32'hDEADBEEF;

  i2s_rx_bram_capture #(
    .BCLK_DIV   (Div),
    .SLOT_BITS  (32),
    .SAMPLE_BITS(24),
    .BUF_WORDS  (Words),
    .BRAM_BASE  (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rec_bclk (rec_bclk),
    .rec_lrclk(rec_lrclk),
    .rec_dat  (rec_dat),
    .BRAM_addr(bram_addr),
    .BRAM_clk (bram_clk),
    .BRAM_din (bram_din),
    .BRAM_dout(bram_dout),
    .BRAM_en  (bram_en),
    .BRAM_rst (bram_rst),
    .BRAM_we  (bram_we),
    .wr_index (wr_index),
    .irq_half (irq_half),
    .irq_wrap (irq_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic        half;
    logic        wrap;
  } wr_t;

  wr_t         exp_q[$];
  logic [23:0] samp_q[$];
  int          total = 0;
  int          bad = 0;
  int          writes = 0;

  int          codec_k = 0;
  int          exp_idx = 0;
  bit          codec_on = 0;
  bit          suppress = 0;
  logic        fill = 1'b0;
  logic [23:0] cur = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sext24(input logic [23:0] s);
    return s[23] ? {8'hFF, s} : {8'h00, s};
  endfunction

  // Codec: one bit per bclk fall; slot bit 0 and bits 25..31 carry the fill value.
  always @(negedge rec_bclk) begin
    if (codec_on) begin
      int unsigned p;
      int unsigned bi;
      codec_k++;
      p = codec_k % 32;
      if (p == 0) cur = (samp_q.size() > 0) ? samp_q.pop_front() : 24'h0;
      if (p >= 1 && p <= 24) begin
        bi = 24 - p;
        rec_dat = cur[bi[4:0]];
      end else begin
        rec_dat = fill;
      end
      if (p == 24 && !suppress) begin
        wr_t e;
        e.addr  = 32'(exp_idx * 4);
        e.din   = sext24(cur);
        e.half  = (exp_idx == Words / 2 - 1);
        e.wrap  = (exp_idx == Words - 1);
        exp_q.push_back(e);
        exp_idx = (exp_idx + 1) % Words;
      end
    end
  end

  // Monitor: pops the scoreboard on every BRAM write and checks clock timing.
  bit  post = 0;
  wr_t pend;
  int  cyc = 0;
  int  last_brise = -1;
  int  last_lrise = -1;
  logic pb = 1'b0;
  logic plr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (post) begin
      check("irq_half", 32'(irq_half), 32'(pend.half));
      check("irq_wrap", 32'(irq_wrap), 32'(pend.wrap));
      check("wr_index", 32'(wr_index), (pend.addr / 4 + 1) % Words);
      post = 0;
    end else if (irq_half || irq_wrap) begin
      check("irq_spurious", 32'({irq_half, irq_wrap}), 32'h0);
    end
    if (bram_en) begin
      if (exp_q.size() == 0) begin
        check("bram_en_unexpected", 32'(bram_en), 32'h0);
      end else begin
        pend = exp_q.pop_front();
        check("bram_addr", bram_addr, pend.addr);
        check("bram_din", bram_din, pend.din);
        check("bram_we", 32'(bram_we), 32'hF);
        post = 1;
        writes++;
      end
    end else if (bram_we != 4'h0) begin
      check("we_without_en", 32'(bram_we), 32'h0);
    end
    if (!enable || rst) begin
      last_brise = -1;
      last_lrise = -1;
    end else begin
      if (rec_bclk && !pb) begin
        if (last_brise >= 0) check("bclk_period", 32'(cyc - last_brise), Div);
        last_brise = cyc;
      end
      if (rec_lrclk != plr) begin
        check("lr_on_bclk_fall", 32'({pb, rec_bclk}), 32'h2);
        if (rec_lrclk) begin
          if (last_lrise >= 0) check("lrclk_period", 32'(cyc - last_lrise), 64 * Div);
          last_lrise = cyc;
        end
      end
    end
    pb  = rec_bclk;
    plr = rec_lrclk;
  end

  task automatic start_run();
    codec_k  = 0;
    exp_idx  = 0;
    cur      = samp_q.pop_front();
    rec_dat  = fill;
    codec_on = 1;
    @(posedge clk) #1 enable = 1'b1;
  endtask

  task automatic stop_run();
    @(posedge clk) #1;
    codec_on = 0;
    enable   = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (writes < n && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("wait_writes_timeout", 32'(writes >= n), 32'h1);
  endtask

  task automatic wait_k(input int k);
    int t = 0;
    while (codec_k < k && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("wait_bits_timeout", 32'(codec_k >= k), 32'h1);
  endtask

  task automatic check_idle(input string tag, input bit chk_idx);
    @(negedge clk);
    check({tag, "_bclk"}, 32'(rec_bclk), 32'h0);
    check({tag, "_lrclk"}, 32'(rec_lrclk), 32'h0);
    check({tag, "_en"}, 32'(bram_en), 32'h0);
    check({tag, "_we"}, 32'(bram_we), 32'h0);
    check({tag, "_din"}, bram_din, 32'h0);
    check({tag, "_addr"}, bram_addr, 32'h0);
    check({tag, "_irq"}, 32'({irq_half, irq_wrap}), 32'h0);
    if (chk_idx) check({tag, "_wr_index"}, 32'(wr_index), 32'h0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    enable = 1'b0;
    rec_dat = 1'b0;
    repeat (4) @(posedge clk);
    check_idle("reset", 1);
    @(posedge clk) #1 rst = 1'b0;

    // Directed samples first, then random ones; 9 writes wrap the ring once.
    fill = 1'b1;
    samp_q = {24'h123456, 24'h800001, 24'h000000};
    repeat (9) samp_q.push_back(24'($urandom));
    start_run();
    wait_writes(9);
    wait_k(4 * 64 + 32 + 10);
    stop_run();
    repeat (20) @(posedge clk);
    check_idle("disable", 0);
    check("scoreboard_empty_a", 32'(exp_q.size()), 32'h0);

    // Re-enable restarts the ring at index 0 with a left sample.
    fill = 1'($urandom);
    samp_q.delete();
    repeat (6) samp_q.push_back(24'($urandom));
    base = writes;
    start_run();
    wait_writes(base + 4);
    stop_run();
    repeat (20) @(posedge clk);
    check("scoreboard_empty_b", 32'(exp_q.size()), 32'h0);

    // Reset shortly before the right-channel write: nothing is written.
    fill = 1'b0;
    samp_q.delete();
    repeat (4) samp_q.push_back(24'($urandom) | 24'h800000);
    base = writes;
    start_run();
    wait_writes(base + 1);
    suppress = 1;
    wait_k(32 + 24);
    @(posedge clk);
    @(posedge clk) #1;
    rst      = 1'b1;
    codec_on = 0;
    enable   = 1'b0;
    repeat (5) @(posedge clk);
    check_idle("midreset", 1);
    @(posedge clk) #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    suppress = 0;
    check("writes_after_reset", 32'(writes), 32'(base + 1));
    check("scoreboard_empty_c", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
